pw_entry_ctrl: RTL and testbench

Sequencing controller for the 4-digit password-entry datapath, built from four 4-bit shift-register slices whose outputs are IB0..IB3.
- Turns raw keypad codes into single-cycle shift strobes.
- Counts entered digits, handles Clear, Enter and inactivity timeout.
- Compares the captured digits against the stored password.
- Drives the unlock window and the lockout alarm after repeated failures.

---
 rtl/pw_entry_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_pw_entry_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_entry_ctrl.sv
// pw_entry_ctrl: keypad sequencing, password compare, unlock window, lockout.
// Build option KEY_SYNC_EN adds a 2-flop Key synchronizer (2 cycles extra).
module pw_entry_ctrl #(
  parameter logic [15:0] PW          = 16'h1234,
  parameter int          MAX_FAIL    = 3,
  parameter int          UNLOCK_CYC  = 500,
  parameter int          LOCKOUT_CYC = 1000,
  parameter int          TIMEOUT_CYC = 5000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Key,
  input  logic [3:0] IB0,
  input  logic [3:0] IB1,
  input  logic [3:0] IB2,
  input  logic [3:0] IB3,
  output logic       sr_shift,
  output logic [3:0] sr_din,
  output logic       sr_clr,
  output logic       unlock,
  output logic       alarm,
  output logic       err,
  output logic [2:0] digit_cnt,
  output logic [2:0] fail_cnt
);

  localparam int MAX_A   = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0] UNL_LD = TW'(UNLOCK_CYC - 1);
  localparam logic [TW-1:0] LCK_LD = TW'(LOCKOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_LD = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    MAX_F  = 3'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_FAIL,
    S_UNLOCK,
    S_LOCKOUT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    key_prev_q, key_prev_d;
  logic          sr_shift_q, sr_shift_d;
  logic [3:0]    sr_din_q, sr_din_d;
  logic          sr_clr_q, sr_clr_d;
  logic          unlock_q, unlock_d;
  logic          alarm_q, alarm_d;
  logic          err_q, err_d;
  logic [2:0]    digit_cnt_q, digit_cnt_d;
  logic [2:0]    fail_cnt_q, fail_cnt_d;

  logic [3:0] key_s;
  logic       press, is_digit, is_clear, is_enter;
  logic       do_fail;
  logic [2:0] fail_inc;

`ifdef KEY_SYNC_EN
  logic [3:0] key_s1_q, key_s2_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
    end else begin
      key_s1_q <= Key;
      key_s2_q <= key_s1_q;
    end
  end

  assign key_s = key_s2_q;
`else
  assign key_s = Key;
`endif

  always_comb begin
    press    = (key_s != 4'h0) && (key_prev_q == 4'h0);
    is_digit = press && (key_s <= 4'hD);
    is_clear = press && (key_s == 4'hE);
    is_enter = press && (key_s == 4'hF);
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = (timer_q != '0) ? timer_q - TW'(1) : '0;
    key_prev_d  = key_s;
    sr_shift_d  = 1'b0;
    sr_din_d    = 4'h0;
    sr_clr_d    = 1'b0;
    unlock_d    = 1'b0;
    alarm_d     = 1'b0;
    err_d       = 1'b0;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    fail_inc    = fail_cnt_q + 3'd1;
    do_fail     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (is_digit) begin
          sr_shift_d  = 1'b1;
          sr_din_d    = key_s;
          digit_cnt_d = 3'd1;
          timer_d     = TMO_LD;
          state_d     = S_ENTRY;
        end else if (is_clear) begin
          sr_clr_d = 1'b1;
        end
      end
      S_ENTRY: begin
        // an event at the expiry edge takes priority over the timeout
        if (is_digit) begin
          timer_d = TMO_LD;
          if (digit_cnt_q < 3'd4) begin
            sr_shift_d  = 1'b1;
            sr_din_d    = key_s;
            digit_cnt_d = digit_cnt_q + 3'd1;
          end
        end else if (is_clear) begin
          timer_d     = '0;
          sr_clr_d    = 1'b1;
          digit_cnt_d = 3'd0;
          state_d     = S_IDLE;
        end else if (is_enter) begin
          timer_d = '0;
          if (digit_cnt_q == 3'd4) state_d = S_CHECK;
          else do_fail = 1'b1;
        end else if (timer_q == '0) begin
          sr_clr_d    = 1'b1;
          digit_cnt_d = 3'd0;
          state_d     = S_IDLE;
        end
      end
      S_CHECK: begin
        if ({IB3, IB2, IB1, IB0} == PW) begin
          fail_cnt_d = 3'd0;
          unlock_d   = 1'b1;
          timer_d    = UNL_LD;
          state_d    = S_UNLOCK;
        end else begin
          do_fail = 1'b1;
        end
      end
      S_FAIL: begin
        state_d = S_IDLE;
      end
      S_UNLOCK: begin
        if (is_clear || timer_q == '0) begin
          timer_d     = '0;
          sr_clr_d    = 1'b1;
          digit_cnt_d = 3'd0;
          state_d     = S_IDLE;
        end else begin
          unlock_d = 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          fail_cnt_d  = 3'd0;
          sr_clr_d    = 1'b1;
          digit_cnt_d = 3'd0;
          state_d     = S_IDLE;
        end else begin
          alarm_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_fail) begin
      fail_cnt_d = fail_inc;
      err_d      = 1'b1;
      if (fail_inc == MAX_F) begin
        alarm_d = 1'b1;
        timer_d = LCK_LD;
        state_d = S_LOCKOUT;
      end else begin
        sr_clr_d    = 1'b1;
        digit_cnt_d = 3'd0;
        state_d     = S_FAIL;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      key_prev_q  <= '0;
      sr_shift_q  <= 1'b0;
      sr_din_q    <= '0;
      sr_clr_q    <= 1'b0;
      unlock_q    <= 1'b0;
      alarm_q     <= 1'b0;
      err_q       <= 1'b0;
      digit_cnt_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      key_prev_q  <= key_prev_d;
      sr_shift_q  <= sr_shift_d;
      sr_din_q    <= sr_din_d;
      sr_clr_q    <= sr_clr_d;
      unlock_q    <= unlock_d;
      alarm_q     <= alarm_d;
      err_q       <= err_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign sr_shift  = sr_shift_q;
  assign sr_din    = sr_din_q;
  assign sr_clr    = sr_clr_q;
  assign unlock    = unlock_q;
  assign alarm     = alarm_q;
  assign err       = err_q;
  assign digit_cnt = digit_cnt_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_pw_entry_ctrl.sv
// Directed bench for pw_entry_ctrl with a behavioural 4x4-bit shift datapath.
// Works in both builds; key latency follows KEY_SYNC_EN.
module tb_pw_entry_ctrl;

`ifdef KEY_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] Key = 4'h0;
  logic [3:0] ib0 = 4'h0, ib1 = 4'h0, ib2 = 4'h0, ib3 = 4'h0;
  logic       sr_shift, sr_clr, unlock, alarm, err;
  logic [3:0] sr_din;
  logic [2:0] digit_cnt, fail_cnt;

  int vectors = 0;
  int miscompares = 0;
  int n_shift = 0, n_clr = 0, n_unlock = 0, n_alarm = 0, n_err = 0;
  int shq[$];

  always #5 CLK = ~CLK;

  pw_entry_ctrl #(
    .PW(16'h1234), .MAX_FAIL(3), .UNLOCK_CYC(8),
    .LOCKOUT_CYC(10), .TIMEOUT_CYC(16)
  ) dut (
    .CLK(CLK), .RST(RST), .Key(Key),
    .IB0(ib0), .IB1(ib1), .IB2(ib2), .IB3(ib3),
    .sr_shift(sr_shift), .sr_din(sr_din), .sr_clr(sr_clr),
    .unlock(unlock), .alarm(alarm), .err(err),
    .digit_cnt(digit_cnt), .fail_cnt(fail_cnt)
  );

  // external shift-register datapath
  always @(posedge CLK) begin
    if (RST || sr_clr) begin
      ib0 <= 4'h0; ib1 <= 4'h0; ib2 <= 4'h0; ib3 <= 4'h0;
    end else if (sr_shift) begin
      ib0 <= sr_din; ib1 <= ib0; ib2 <= ib1; ib3 <= ib2;
    end
  end

  always @(posedge CLK) begin
    #2;
    if (sr_shift === 1'b1) begin
      n_shift++;
      shq.push_back(int'(sr_din));
    end
    if (sr_clr === 1'b1) n_clr++;
    if (unlock === 1'b1) n_unlock++;
    if (alarm === 1'b1) n_alarm++;
    if (err === 1'b1) n_err++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge CLK); Key = k;
    @(negedge CLK); Key = 4'h0;
  endtask

  task automatic enter4(input logic [3:0] a, b, c, d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLK);
    vectors++; if (sr_shift !== 1'b0) begin miscompares++; $display("FAIL rst_shift: got %b want 0", sr_shift); end
    vectors++; if (sr_din !== 4'h0) begin miscompares++; $display("FAIL rst_din: got %h want 0", sr_din); end
    vectors++; if (sr_clr !== 1'b0) begin miscompares++; $display("FAIL rst_clr: got %b want 0", sr_clr); end
    vectors++; if (unlock !== 1'b0) begin miscompares++; $display("FAIL rst_unlock: got %b want 0", unlock); end
    vectors++; if (alarm !== 1'b0) begin miscompares++; $display("FAIL rst_alarm: got %b want 0", alarm); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", err); end
    vectors++; if (digit_cnt !== 3'd0) begin miscompares++; $display("FAIL rst_dcnt: got %0d want 0", digit_cnt); end
    vectors++; if (fail_cnt !== 3'd0) begin miscompares++; $display("FAIL rst_fcnt: got %0d want 0", fail_cnt); end
    RST = 1'b0;
    idle(2);
  endtask

  task automatic test_unlock;
    int s_sh, s_clr, s_unl, base;
    s_sh = n_shift; s_clr = n_clr; s_unl = n_unlock; base = shq.size();
    @(negedge CLK); Key = 4'h1;
    @(negedge CLK); Key = 4'h0;
    repeat (LAT - 1) @(negedge CLK);
    vectors++; if (sr_shift !== 1'b1) begin miscompares++; $display("FAIL latency_shift: got %b want 1", sr_shift); end
    vectors++; if (sr_din !== 4'h1) begin miscompares++; $display("FAIL latency_din: got %h want 1", sr_din); end
    press(4'h2); press(4'h3); press(4'h4);
    idle(LAT + 1);
    vectors++; if (digit_cnt !== 3'd4) begin miscompares++; $display("FAIL unl_dcnt: got %0d want 4", digit_cnt); end
    vectors++; if (n_shift - s_sh !== 4) begin miscompares++; $display("FAIL unl_nshift: got %0d want 4", n_shift - s_sh); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (shq.size() <= base + i || shq[base + i] != i + 1) begin
        miscompares++;
        $display("FAIL unl_din%0d: got %0d want %0d", i, (shq.size() > base + i) ? shq[base + i] : -1, i + 1);
      end
    end
    press(4'hF);
    idle(LAT + 12);
    vectors++; if (n_unlock - s_unl !== 8) begin miscompares++; $display("FAIL unl_cycles: got %0d want 8", n_unlock - s_unl); end
    vectors++; if (n_clr - s_clr !== 1) begin miscompares++; $display("FAIL unl_clr: got %0d want 1", n_clr - s_clr); end
    vectors++; if (unlock !== 1'b0) begin miscompares++; $display("FAIL unl_end: got %b want 0", unlock); end
    vectors++; if (digit_cnt !== 3'd0) begin miscompares++; $display("FAIL unl_end_dcnt: got %0d want 0", digit_cnt); end
  endtask

  task automatic test_lockout;
    int s_err, s_al, s_clr;
    for (int a = 1; a <= 3; a++) begin
      s_err = n_err; s_al = n_alarm; s_clr = n_clr;
      enter4(4'h1, 4'h2, 4'h3, 4'h5);
      press(4'hF);
      if (a < 3) begin
        idle(LAT + 4);
        vectors++; if (n_err - s_err !== 1) begin miscompares++; $display("FAIL lk_err%0d: got %0d want 1", a, n_err - s_err); end
        vectors++; if (fail_cnt !== 3'(a)) begin miscompares++; $display("FAIL lk_fcnt%0d: got %0d want %0d", a, fail_cnt, a); end
        vectors++; if (alarm !== 1'b0) begin miscompares++; $display("FAIL lk_noalarm%0d: got %b want 0", a, alarm); end
        vectors++; if (digit_cnt !== 3'd0) begin miscompares++; $display("FAIL lk_dcnt%0d: got %0d want 0", a, digit_cnt); end
      end else begin
        repeat (LAT) @(negedge CLK);
        vectors++; if (alarm !== 1'b1) begin miscompares++; $display("FAIL lk_alarm_on: got %b want 1", alarm); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL lk_err_on: got %b want 1", err); end
        vectors++; if (fail_cnt !== 3'd3) begin miscompares++; $display("FAIL lk_fcnt3: got %0d want 3", fail_cnt); end
        press(4'hE);
        idle(14);
        vectors++; if (n_alarm - s_al !== 10) begin miscompares++; $display("FAIL lk_alarm_cyc: got %0d want 10", n_alarm - s_al); end
        vectors++; if (n_err - s_err !== 1) begin miscompares++; $display("FAIL lk_err_pulse: got %0d want 1", n_err - s_err); end
        vectors++; if (n_clr - s_clr !== 1) begin miscompares++; $display("FAIL lk_clr: got %0d want 1", n_clr - s_clr); end
        vectors++; if (fail_cnt !== 3'd0) begin miscompares++; $display("FAIL lk_fcnt_end: got %0d want 0", fail_cnt); end
        vectors++; if (alarm !== 1'b0) begin miscompares++; $display("FAIL lk_alarm_off: got %b want 0", alarm); end
      end
    end
  endtask

  task automatic test_clear;
    int s_clr, s_sh, s_unl;
    s_clr = n_clr; s_sh = n_shift;
    press(4'h1); press(4'h2); press(4'hE);
    idle(LAT + 1);
    vectors++; if (n_clr - s_clr !== 1) begin miscompares++; $display("FAIL clr_pulse: got %0d want 1", n_clr - s_clr); end
    vectors++; if (n_shift - s_sh !== 2) begin miscompares++; $display("FAIL clr_nshift: got %0d want 2", n_shift - s_sh); end
    vectors++; if (digit_cnt !== 3'd0) begin miscompares++; $display("FAIL clr_dcnt: got %0d want 0", digit_cnt); end
    s_unl = n_unlock;
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hF);
    idle(LAT + 12);
    vectors++; if (n_unlock - s_unl !== 8) begin miscompares++; $display("FAIL clr_unlock: got %0d want 8", n_unlock - s_unl); end
  endtask

  task automatic test_fifth_digit;
    int s_sh, s_unl, s_err, base;
    s_sh = n_shift; s_unl = n_unlock; base = shq.size();
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'h6);
    idle(LAT + 1);
    vectors++; if (n_shift - s_sh !== 4) begin miscompares++; $display("FAIL d5_nshift: got %0d want 4", n_shift - s_sh); end
    vectors++; if (digit_cnt !== 3'd4) begin miscompares++; $display("FAIL d5_dcnt: got %0d want 4", digit_cnt); end
    vectors++;
    if (shq.size() <= base + 3 || shq[base + 3] != 4) begin
      miscompares++;
      $display("FAIL d5_last_din: got %0d want 4", (shq.size() > base + 3) ? shq[base + 3] : -1);
    end
    press(4'hF);
    idle(LAT + 12);
    vectors++; if (n_unlock - s_unl !== 8) begin miscompares++; $display("FAIL d5_unlock: got %0d want 8", n_unlock - s_unl); end
    s_err = n_err;
    press(4'h7); press(4'hF);
    idle(LAT + 3);
    vectors++; if (n_err - s_err !== 1) begin miscompares++; $display("FAIL short_err: got %0d want 1", n_err - s_err); end
    vectors++; if (fail_cnt !== 3'd1) begin miscompares++; $display("FAIL short_fcnt: got %0d want 1", fail_cnt); end
    vectors++; if (digit_cnt !== 3'd0) begin miscompares++; $display("FAIL short_dcnt: got %0d want 0", digit_cnt); end
  endtask

  task automatic test_hold_timeout;
    int s_sh, s_clr, clr_at;
    s_sh = n_shift; s_clr = n_clr; clr_at = -1;
    @(negedge CLK); Key = 4'h3;
    for (int i = 1; i <= 24; i++) begin
      @(negedge CLK);
      if (sr_clr === 1'b1 && clr_at < 0) clr_at = i;
      if (i == 20) Key = 4'h0;
    end
    vectors++; if (n_shift - s_sh !== 1) begin miscompares++; $display("FAIL hold_nshift: got %0d want 1", n_shift - s_sh); end
    vectors++; if (clr_at !== 16 + LAT) begin miscompares++; $display("FAIL tmo_when: got %0d want %0d", clr_at, 16 + LAT); end
    vectors++; if (n_clr - s_clr !== 1) begin miscompares++; $display("FAIL tmo_nclr: got %0d want 1", n_clr - s_clr); end
    vectors++; if (digit_cnt !== 3'd0) begin miscompares++; $display("FAIL tmo_dcnt: got %0d want 0", digit_cnt); end
    vectors++; if (fail_cnt !== 3'd1) begin miscompares++; $display("FAIL tmo_fcnt: got %0d want 1", fail_cnt); end
  endtask

  task automatic test_timeout_race;
    int s_clr;
    s_clr = n_clr;
    press(4'h1);
    idle(14);
    press(4'h2);
    idle(LAT + 1);
    vectors++; if (digit_cnt !== 3'd2) begin miscompares++; $display("FAIL race_dcnt: got %0d want 2", digit_cnt); end
    vectors++; if (n_clr - s_clr !== 0) begin miscompares++; $display("FAIL race_noclr: got %0d want 0", n_clr - s_clr); end
    idle(20);
    vectors++; if (digit_cnt !== 3'd0) begin miscompares++; $display("FAIL race_tmo_dcnt: got %0d want 0", digit_cnt); end
    vectors++; if (n_clr - s_clr !== 1) begin miscompares++; $display("FAIL race_tmo_clr: got %0d want 1", n_clr - s_clr); end
  endtask

  task automatic test_reset_unlock;
    int s_unl;
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hF);
    idle(LAT + 3);
    vectors++; if (unlock !== 1'b1) begin miscompares++; $display("FAIL ru_unlock_on: got %b want 1", unlock); end
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    vectors++; if (unlock !== 1'b0) begin miscompares++; $display("FAIL ru_unlock: got %b want 0", unlock); end
    vectors++; if (alarm !== 1'b0) begin miscompares++; $display("FAIL ru_alarm: got %b want 0", alarm); end
    vectors++; if (digit_cnt !== 3'd0) begin miscompares++; $display("FAIL ru_dcnt: got %0d want 0", digit_cnt); end
    vectors++; if (sr_clr !== 1'b0) begin miscompares++; $display("FAIL ru_clr: got %b want 0", sr_clr); end
    idle(2);
    s_unl = n_unlock;
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hF);
    idle(LAT + 12);
    vectors++; if (n_unlock - s_unl !== 8) begin miscompares++; $display("FAIL ru_reunlock: got %0d want 8", n_unlock - s_unl); end
  endtask

  task automatic test_reset_lockout;
    int s_al;
    for (int a = 0; a < 3; a++) begin
      press(4'h7); press(4'hF);
      if (a < 2) idle(LAT + 3);
    end
    idle(LAT + 2);
    vectors++; if (alarm !== 1'b1) begin miscompares++; $display("FAIL rl_alarm_on: got %b want 1", alarm); end
    vectors++; if (fail_cnt !== 3'd3) begin miscompares++; $display("FAIL rl_fcnt_on: got %0d want 3", fail_cnt); end
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    vectors++; if (alarm !== 1'b0) begin miscompares++; $display("FAIL rl_alarm: got %b want 0", alarm); end
    vectors++; if (fail_cnt !== 3'd0) begin miscompares++; $display("FAIL rl_fcnt: got %0d want 0", fail_cnt); end
    s_al = n_alarm;
    idle(12);
    vectors++; if (n_alarm - s_al !== 0) begin miscompares++; $display("FAIL rl_alarm_gone: got %0d want 0", n_alarm - s_al); end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_clear();
    test_fifth_digit();
    test_hold_timeout();
    test_timeout_race();
    test_reset_unlock();
    test_reset_lockout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
